seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Consumer end of the parallel 3-digit seven-segment interface produced by the angle display path (one 7-bit code per digit).
- Time-multiplexes the three digit codes onto one shared segment bus plus three digit enables, for boards with a common-anode multiplexed display.
- New codes are double-buffered: they take effect only at a frame boundary, so a display update never tears mid-frame.
- Includes inter-digit blanking (anti-ghosting) and per-digit blank masking.

Parameters:
- REFRESH_DIV, 50000: clock cycles per digit slot; must be >= 2.
- BLANK_CYCLES, 500: blanked cycles at the start of each slot; must be < REFRESH_DIV and may be 0.
- SEG_ACTIVE_LOW, 1: 1 means the segment "off" level is 7'h7F and codes pass through unchanged; 0 means "off" is 7'h00.
- DIG_ACTIVE_LOW, 1: 1 means a digit is on when its dig_en bit is 0.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous reset, active-high.
- enable, input, 1: scan enable.
- load, input, 1: single-cycle strobe; captures seg_in0..2 and blank_mask.
- seg_in0, input, 7: code for digit 0 (units).
- seg_in1, input, 7: code for digit 1 (tens).
- seg_in2, input, 7: code for digit 2 (hundreds).
- blank_mask, input, 3: bit i=1 forces digit i dark.
- seg_out, output, 7: shared segment bus.
- dig_en, output, 3: digit enables; bit i selects digit i.
- frame_done, output, 1: one-cycle pulse on the last cycle of the digit-2 slot.

Behaviour:
- Reset (async, high): all state cleared.
  - seg_out = OFF, dig_en = all digits off.
  - frame_done = 0, pending = 0.
  - Active and shadow code registers = OFF; masks = 3'b111.
- States: IDLE, BLANK, SHOW.
  - IDLE while enable=0. Outputs are OFF, position counter p is held at 0, frame_done = 0.
- Position counter p runs 0..3*REFRESH_DIV-1.
  - Slot index d = p / REFRESH_DIV; offset o = p % REFRESH_DIV.
  - On the first enabled edge p = 0. It increments once per enabled edge and wraps to 0 after 3*REFRESH_DIV-1.
- Outputs are registered and reflect the p value loaded on the same edge.
  - BLANK when o < BLANK_CYCLES: seg_out = OFF, all digits off.
  - SHOW otherwise: dig_en selects only digit d.
  - In SHOW, seg_out = active code[d], or OFF if active mask[d] = 1. dig_en still selects digit d when masked.
  - Exactly one digit is ever enabled at a time; never two.
- frame_done = 1 exactly when p = 3*REFRESH_DIV-1, one cycle per frame.
- Load handshake:
  - load=1 on an edge copies seg_in0..2 and blank_mask into the shadow registers and sets pending. This applies in any state, including IDLE.
  - A second load before the transfer overwrites the shadow; last load wins.
- Transfer: shadow is copied to active on the edge where p goes to 0, either by wrap or by leaving IDLE, and pending is cleared.
  - If load coincides with that edge, the new inputs go straight to active and pending ends at 0.
- Enable deasserted mid-frame: go to IDLE on the next edge and discard the frame position.
  - Re-enable restarts at p = 0 (BLANK of digit 0, or SHOW if BLANK_CYCLES = 0) and applies any pending data.
- Reset mid-frame: immediate return to the reset values; pending data is lost.
- Nothing in this block affects the upstream pipeline; load is never back-pressured.

Test Plan:
Common settings: REFRESH_DIV=8, BLANK_CYCLES=2, active-low.
1. Reset, then load seg_in0=7'h40, seg_in1=7'h79, seg_in2=7'h24, mask=0, enable=1.
   - Frame 1 (cycles 0-23) shows OFF; load is pending until the first transfer.
   - Frame 2: cycles 0-1 dig_en=3'b111, seg=7'h7F. Cycles 2-7 dig_en=3'b110, seg=7'h40. Cycles 10-15 dig_en=3'b101, seg=7'h79. Cycles 18-23 dig_en=3'b011, seg=7'h24.
   - frame_done is high only at cycle 23.
2. Load 7'h12 at frame cycle 12, then 7'h30 at cycle 20 → current frame unchanged; the next frame shows 7'h30 (last load wins, no tearing).
3. Load coincident with the wrap edge (cycle 23→0) → new code visible at cycle 2 of the immediately starting frame.
4. blank_mask=3'b100 → cycles 18-23 give dig_en=3'b011 with seg=7'h7F; digits 0 and 1 are unaffected.
5. enable dropped at cycle 13 → outputs OFF and frame_done=0 while low. Re-enable → cycles 0-1 blank, digit 0 at cycle 2.
6. Assert reset asynchronously mid-SHOW (between edges) → seg_out=7'h7F and dig_en=3'b111 immediately. After release, a display with no load stays OFF.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Three-digit multiplexed seven-segment scanner with frame-aligned double buffering,
// inter-digit blanking and per-digit blank masking.
module seg_scan_driver #(
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       load,
  input  logic [6:0] seg_in0,
  input  logic [6:0] seg_in1,
  input  logic [6:0] seg_in2,
  input  logic [2:0] blank_mask,
  output logic [6:0] seg_out,
  output logic [2:0] dig_en,
  output logic       frame_done
);

  localparam int            OW        = $clog2(REFRESH_DIV);
  localparam logic [OW-1:0] LAST_OFF  = OW'(REFRESH_DIV - 1);
  localparam logic [OW-1:0] BLANK_LEN = OW'(BLANK_CYCLES);
  localparam logic [6:0]    SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [2:0]    DIG_OFF   = DIG_ACTIVE_LOW ? 3'b111 : 3'b000;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t          state_q, state_d;
  logic [1:0]      slot_q, slot_d;
  logic [OW-1:0]   off_q, off_d;
  logic [2:0][6:0] act_q, act_d;
  logic [2:0][6:0] shd_q, shd_d;
  logic [2:0]      mact_q, mact_d;
  logic [2:0]      mshd_q, mshd_d;
  logic            pending_q, pending_d;
  logic [6:0]      seg_q, seg_d;
  logic [2:0]      dig_q, dig_d;
  logic            done_q, done_d;

  logic [2:0][6:0] seg_in_w;
  logic            frame_end;
  logic            restart;
  logic [2:0]      dig_sel;

  assign seg_in_w = {seg_in2, seg_in1, seg_in0};

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    off_d     = off_q;
    act_d     = act_q;
    shd_d     = shd_q;
    mact_d    = mact_q;
    mshd_d    = mshd_q;
    pending_d = pending_q;
    seg_d     = SEG_OFF;
    dig_d     = DIG_OFF;
    done_d    = 1'b0;
    dig_sel   = 3'b000;

    frame_end = (slot_q == 2'd2) && (off_q == LAST_OFF);
    // The frame position returns to 0 either by wrapping or by leaving IDLE.
    restart   = enable && ((state_q == IDLE) || frame_end);

    if (!enable) begin
      state_d = IDLE;
      slot_d  = 2'd0;
      off_d   = '0;
    end else begin
      if (restart) begin
        slot_d = 2'd0;
        off_d  = '0;
      end else if (off_q == LAST_OFF) begin
        slot_d = slot_q + 2'd1;
        off_d  = '0;
      end else begin
        off_d = off_q + OW'(1);
      end
      state_d = (off_d < BLANK_LEN) ? BLANK : SHOW;
    end

    if (load) begin
      shd_d  = seg_in_w;
      mshd_d = blank_mask;
    end

    // A load on the restart edge bypasses the shadow so nothing stays pending.
    if (restart) begin
      if (load) begin
        act_d  = seg_in_w;
        mact_d = blank_mask;
      end else if (pending_q) begin
        act_d  = shd_q;
        mact_d = mshd_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      pending_d = 1'b1;
    end

    if (state_d == SHOW) begin
      dig_sel = 3'b001 << slot_d;
      dig_d   = DIG_ACTIVE_LOW ? ~dig_sel : dig_sel;
      seg_d   = mact_d[slot_d] ? SEG_OFF : act_d[slot_d];
    end
    done_d = enable && (slot_d == 2'd2) && (off_d == LAST_OFF);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      slot_q    <= 2'd0;
      off_q     <= '0;
      act_q     <= {3{SEG_OFF}};
      shd_q     <= {3{SEG_OFF}};
      mact_q    <= 3'b111;
      mshd_q    <= 3'b111;
      pending_q <= 1'b0;
      seg_q     <= SEG_OFF;
      dig_q     <= DIG_OFF;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      off_q     <= off_d;
      act_q     <= act_d;
      shd_q     <= shd_d;
      mact_q    <= mact_d;
      mshd_q    <= mshd_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      dig_q     <= dig_d;
      done_q    <= done_d;
    end
  end

  assign seg_out    = seg_q;
  assign dig_en     = dig_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed frame table, hand-written corner sequences,
// then random stimulus against a frame-position reference model.
module tb_seg_scan_driver;

  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FRAME = 3 * RD;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       load;
  logic [6:0] s0, s1, s2;
  logic [2:0] bm;
  logic [6:0] seg_out;
  logic [2:0] dig_en;
  logic       frame_done;

  int checks = 0;
  int failures = 0;

  seg_scan_driver #(
    .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load),
    .seg_in0(s0), .seg_in1(s1), .seg_in2(s2), .blank_mask(bm),
    .seg_out(seg_out), .dig_en(dig_en), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Reference model: frame position as a plain integer plus display buffers.
  int         m_p;
  bit         m_idle;
  logic [6:0] m_act [3];
  logic [6:0] m_shd [3];
  logic [2:0] m_mact, m_mshd;
  bit         m_pend;

  task automatic model_reset();
    m_p = 0; m_idle = 1'b1; m_pend = 1'b0;
    m_mact = 3'b111; m_mshd = 3'b111;
    for (int i = 0; i < 3; i++) begin m_act[i] = 7'h7F; m_shd[i] = 7'h7F; end
  endtask

  task automatic model_step(input bit en, input bit ld, input logic [6:0] a, b, c,
                            input logic [2:0] m);
    bit xfer;
    xfer = en && (m_idle || m_p == FRAME - 1);
    if (!en) begin
      m_idle = 1'b1; m_p = 0;
    end else begin
      m_p = xfer ? 0 : m_p + 1;
      m_idle = 1'b0;
    end
    if (ld) begin
      m_shd[0] = a; m_shd[1] = b; m_shd[2] = c; m_mshd = m;
    end
    if (xfer) begin
      if (ld || m_pend) begin
        for (int i = 0; i < 3; i++) m_act[i] = m_shd[i];
        m_mact = m_mshd;
      end
      m_pend = 1'b0;
    end else if (ld) begin
      m_pend = 1'b1;
    end
  endtask

  task automatic model_exp(output logic [6:0] es, output logic [2:0] ed, output logic edn);
    int d, o;
    logic [2:0] oh;
    es = 7'h7F; ed = 3'b111; edn = 1'b0;
    if (!m_idle) begin
      d = m_p / RD;
      o = m_p % RD;
      if (o >= BC) begin
        oh = 3'b001 << d;
        ed = ~oh;
        es = m_mact[d] ? 7'h7F : m_act[d];
      end
      edn = (m_p == FRAME - 1);
    end
  endtask

  task automatic chk(input string nm, input logic [6:0] es, input logic [2:0] ed,
                     input logic edn);
    checks++;
    if (seg_out !== es || dig_en !== ed || frame_done !== edn) begin
      failures++;
      $display("FAIL %s: got seg_out=%h dig_en=%b frame_done=%b, expected seg_out=%h dig_en=%b frame_done=%b",
               nm, seg_out, dig_en, frame_done, es, ed, edn);
    end else begin
      $display("ok   %s: seg_out=%h dig_en=%b frame_done=%b p=%0d", nm, seg_out, dig_en,
               frame_done, m_p);
    end
  endtask

  task automatic chk_model(input string nm);
    logic [6:0] es; logic [2:0] ed; logic edn;
    model_exp(es, ed, edn);
    chk(nm, es, ed, edn);
  endtask

  task automatic step(input bit en, input bit ld, input logic [6:0] a, b, c,
                      input logic [2:0] m);
    enable = en; load = ld; s0 = a; s1 = b; s2 = c; bm = m;
    @(posedge clk);
    model_step(en, ld, a, b, c, m);
    #1;
    load = 1'b0;
  endtask

  task automatic run_to(input int target, input string nm);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (!m_idle && m_p == target) begin hit = 1'b1; break; end
      step(1'b1, 1'b0, 7'h00, 7'h00, 7'h00, 3'b000);
      chk_model(nm);
    end
    if (!hit) begin
      checks++; failures++;
      $display("FAIL %s: position %0d not reached within budget", nm, target);
    end
  endtask

  typedef struct {
    bit         en;
    bit         ld;
    logic [6:0] a, b, c;
    logic [2:0] m;
    int         n;
    logic [6:0] seg;
    logic [2:0] dig;
    bit         done;
  } row_t;

  row_t rows[$];

  task automatic add(input bit en, input bit ld, input logic [6:0] a, b, c,
                     input logic [2:0] m, input int n, input logic [6:0] seg,
                     input logic [2:0] dig, input bit done);
    row_t r;
    r.en = en; r.ld = ld; r.a = a; r.b = b; r.c = c; r.m = m;
    r.n = n; r.seg = seg; r.dig = dig; r.done = done;
    rows.push_back(r);
  endtask

  // A frame with steady inputs showing codes x/y/z (7F where dark).
  task automatic add_frame(input logic [6:0] x, y, z);
    add(1, 0, 0, 0, 0, 0, 2, 7'h7F, 3'b111, 0);
    add(1, 0, 0, 0, 0, 0, 6, x,     3'b110, 0);
    add(1, 0, 0, 0, 0, 0, 2, 7'h7F, 3'b111, 0);
    add(1, 0, 0, 0, 0, 0, 6, y,     3'b101, 0);
    add(1, 0, 0, 0, 0, 0, 2, 7'h7F, 3'b111, 0);
    add(1, 0, 0, 0, 0, 0, 5, z,     3'b011, 0);
    add(1, 0, 0, 0, 0, 0, 1, z,     3'b011, 1);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; load = 1'b0;
    s0 = '0; s1 = '0; s2 = '0; bm = '0;
    model_reset();

    // Frame 1: enable first, load one cycle later so it stays pending.
    add(1, 0, 0, 0, 0, 0, 1, 7'h7F, 3'b111, 0);
    add(1, 1, 7'h40, 7'h79, 7'h24, 3'b000, 1, 7'h7F, 3'b111, 0);
    add(1, 0, 0, 0, 0, 0, 6, 7'h7F, 3'b110, 0);
    add(1, 0, 0, 0, 0, 0, 2, 7'h7F, 3'b111, 0);
    add(1, 0, 0, 0, 0, 0, 6, 7'h7F, 3'b101, 0);
    add(1, 0, 0, 0, 0, 0, 2, 7'h7F, 3'b111, 0);
    add(1, 0, 0, 0, 0, 0, 5, 7'h7F, 3'b011, 0);
    add(1, 0, 0, 0, 0, 0, 1, 7'h7F, 3'b011, 1);
    add_frame(7'h40, 7'h79, 7'h24);
    // Frame 3: two mid-frame loads, display must not change.
    add(1, 0, 0, 0, 0, 0, 2, 7'h7F, 3'b111, 0);
    add(1, 0, 0, 0, 0, 0, 6, 7'h40, 3'b110, 0);
    add(1, 0, 0, 0, 0, 0, 2, 7'h7F, 3'b111, 0);
    add(1, 0, 0, 0, 0, 0, 2, 7'h79, 3'b101, 0);
    add(1, 1, 7'h12, 7'h79, 7'h24, 3'b000, 1, 7'h79, 3'b101, 0);
    add(1, 0, 0, 0, 0, 0, 3, 7'h79, 3'b101, 0);
    add(1, 0, 0, 0, 0, 0, 2, 7'h7F, 3'b111, 0);
    add(1, 0, 0, 0, 0, 0, 2, 7'h24, 3'b011, 0);
    add(1, 1, 7'h30, 7'h79, 7'h24, 3'b000, 1, 7'h24, 3'b011, 0);
    add(1, 0, 0, 0, 0, 0, 2, 7'h24, 3'b011, 0);
    add(1, 0, 0, 0, 0, 0, 1, 7'h24, 3'b011, 1);
    add_frame(7'h30, 7'h79, 7'h24);

    #22;
    chk("reset_state", 7'h7F, 3'b111, 1'b0);
    reset = 1'b0;

    foreach (rows[r]) begin
      for (int k = 0; k < rows[r].n; k++) begin
        step(rows[r].en, rows[r].ld, rows[r].a, rows[r].b, rows[r].c, rows[r].m);
        chk($sformatf("table_row%0d", r), rows[r].seg, rows[r].dig, rows[r].done);
      end
    end

    // Load on the wrap edge goes straight to the starting frame.
    step(1, 1, 7'h06, 7'h79, 7'h24, 3'b000);
    chk("wrap_load_p0", 7'h7F, 3'b111, 1'b0);
    step(1, 0, 7'h00, 7'h00, 7'h00, 3'b000);
    step(1, 0, 7'h00, 7'h00, 7'h00, 3'b000);
    chk("wrap_load_p2", 7'h06, 3'b110, 1'b0);

    // Mask digit 2; takes effect next frame.
    step(1, 1, 7'h06, 7'h79, 7'h24, 3'b100);
    chk_model("mask_load");
    run_to(FRAME - 1, "mask_run");
    run_to(2, "mask_run");
    chk("mask_d0", 7'h06, 3'b110, 1'b0);
    run_to(10, "mask_run");
    chk("mask_d1", 7'h79, 3'b101, 1'b0);
    run_to(18, "mask_run");
    chk("mask_d2", 7'h7F, 3'b011, 1'b0);
    run_to(FRAME - 1, "mask_run");
    chk("mask_done", 7'h7F, 3'b011, 1'b1);

    // Enable drop mid-frame and restart.
    run_to(12, "en_run");
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 7'h00, 7'h00, 7'h00, 3'b000);
      chk("en_low", 7'h7F, 3'b111, 1'b0);
    end
    step(1, 0, 7'h00, 7'h00, 7'h00, 3'b000);
    chk("reen_p0", 7'h7F, 3'b111, 1'b0);
    step(1, 0, 7'h00, 7'h00, 7'h00, 3'b000);
    chk("reen_p1", 7'h7F, 3'b111, 1'b0);
    step(1, 0, 7'h00, 7'h00, 7'h00, 3'b000);
    chk("reen_p2", 7'h06, 3'b110, 1'b0);

    // Asynchronous reset between edges while showing digit 0.
    run_to(4, "rst_run");
    #3;
    reset = 1'b1;
    #1;
    chk("async_reset", 7'h7F, 3'b111, 1'b0);
    model_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(1, 0, 7'h00, 7'h00, 7'h00, 3'b000);
    chk("post_reset_p2", 7'h7F, 3'b110, 1'b0);

    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 15) != 0, $urandom_range(0, 4) == 0,
           7'($urandom), 7'($urandom), 7'($urandom), 3'($urandom));
      chk_model("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
